io_port_responder: RTL and testbench

IO_PORT_RESPONDER -- requirements
Module: io_port_responder

---
 rtl/io_port_responder.sv | 203 ++++++++++++++++++++
 tb/tb_io_port_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_responder.sv
// io_port_responder: memory-mapped I/O port for a single-cycle MIPS-style core.
// Registers: PORT_OUT (R/W), PORT_IN (RO), STATUS (RO), CLEAR (WO), FIFO_DATA (RO-pop).
//
// Ports:
//   clk, reset       - single clock, synchronous active-high reset
//   Address          - processor data address (ALU result)
//   WriteData        - store data
//   MemWrite/MemRead - store / load strobes
//   PortIn           - asynchronous external input pins
//   ReadData         - combinational load data (0 when not hit)
//   Hit              - Address selects one of this block's registers
//   PortOut          - registered external output port
module io_port_responder #(
   parameter logic [31:0] BASE_ADDR  = 32'h1001_0040,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [7:0]  PortIn,
   output logic [31:0] ReadData,
   output logic        Hit,
   output logic [31:0] PortOut
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

   // ------------------------------------------------------------
   // Address decode (byte lanes ignored)
   // ------------------------------------------------------------
   logic [29:0] word;
   logic        sel_out;
   logic        sel_in;
   logic        sel_stat;
   logic        sel_clr;
   logic        sel_fifo;
   logic        unused_addr_lsb;

   assign word     = Address[31:2];
   assign sel_out  = (word == BASE_WORD);
   assign sel_in   = (word == BASE_WORD + 30'd1);
   assign sel_stat = (word == BASE_WORD + 30'd2);
   assign sel_clr  = (word == BASE_WORD + 30'd3);
   assign sel_fifo = (word == BASE_WORD + 30'd4);
   assign Hit      = sel_out | sel_in | sel_stat | sel_clr | sel_fifo;

   assign unused_addr_lsb = ^Address[1:0];

   // ------------------------------------------------------------
   // State
   // ------------------------------------------------------------
   logic [31:0]   port_out_q, port_out_d;
   logic [7:0]    sync1_q, sync1_d;
   logic [7:0]    sync2_q, sync2_d;
   logic [7:0]    prev_q, prev_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          change_flag_q, change_flag_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    mem_d [FIFO_DEPTH];

   // ------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------
   logic full;
   logic empty;
   logic change;
   logic pop;
   logic wr_en;
   logic ovf_set;
   logic st_out;
   logic st_clr;

   assign full   = (count_q == CW'(FIFO_DEPTH));
   assign empty  = (count_q == '0);
   assign change = (sync2_q != prev_q);
   assign pop    = MemRead & sel_fifo & ~empty;
   assign st_out = MemWrite & sel_out;
   assign st_clr = MemWrite & sel_clr;

   // A full FIFO still accepts the sample when the head leaves
   // in the same cycle; only an unserviced full push overflows.
   assign wr_en   = change & (~full | pop);
   assign ovf_set = change & full & ~pop;

   always_comb begin
      port_out_d = port_out_q;
      if (st_out) begin
         port_out_d = WriteData;
      end
   end

   always_comb begin
      sync1_d = PortIn;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = sync2_q;
      end
   end

   // Sticky flags: a set in the same cycle beats a clear.
   always_comb begin
      change_flag_d = change_flag_q;
      overflow_d    = overflow_q;
      if (st_clr && WriteData[0]) begin
         change_flag_d = 1'b0;
      end
      if (st_clr && WriteData[1]) begin
         overflow_d = 1'b0;
      end
      if (change) begin
         change_flag_d = 1'b1;
      end
      if (ovf_set) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         port_out_q    <= '0;
         sync1_q       <= '0;
         sync2_q       <= '0;
         prev_q        <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         change_flag_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         port_out_q    <= port_out_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         prev_q        <= prev_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         change_flag_q <= change_flag_d;
         overflow_q    <= overflow_d;
      end
   end

   // Storage is not reset; the pointers make stale entries invisible.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_q <= mem_d;
      end
   end

   // ------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------
   logic [31:0] status;
   logic [31:0] fifo_rd;

   assign status  = {24'b0, overflow_q, change_flag_q,
                     4'(count_q), full, empty};
   assign fifo_rd = empty ? 32'h0 : {24'b0, mem_q[rd_ptr_q]};

   always_comb begin
      ReadData = 32'h0;
      unique case (1'b1)
         sel_out:  ReadData = port_out_q;
         sel_in:   ReadData = {24'b0, sync2_q};
         sel_stat: ReadData = status;
         sel_fifo: ReadData = fifo_rd;
         default:  ReadData = 32'h0;
      endcase
   end

   assign PortOut = port_out_q;

endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder: scoreboard bench for io_port_responder.
// Queue-based reference model; monitor checks every load cycle.
module tb_io_port_responder;

   localparam logic [31:0] BASE = 32'h1001_0040;
   localparam int D = 4;

   localparam logic [31:0] O_OUT  = 32'h00;
   localparam logic [31:0] O_IN   = 32'h04;
   localparam logic [31:0] O_STAT = 32'h08;
   localparam logic [31:0] O_CLR  = 32'h0C;
   localparam logic [31:0] O_FIFO = 32'h10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] Address = '0;
   logic [31:0] WriteData = '0;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [7:0]  PortIn = '0;
   logic [31:0] ReadData;
   logic        Hit;
   logic [31:0] PortOut;

   always #5 clk = ~clk;

   io_port_responder #(
      .BASE_ADDR (BASE),
      .FIFO_DEPTH(D)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .Address  (Address),
      .WriteData(WriteData),
      .MemWrite (MemWrite),
      .MemRead  (MemRead),
      .PortIn   (PortIn),
      .ReadData (ReadData),
      .Hit      (Hit),
      .PortOut  (PortOut)
   );

   typedef struct {
      string       name;
      logic [31:0] data;
      logic        hit;
      logic [31:0] pout;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: pin history {prev, sync2, sync1}, FIFO as a queue.
   logic [31:0] m_pout;
   logic [7:0]  m_pins[$];
   logic [7:0]  m_fifo[$];
   bit          m_cf;
   bit          m_ov;
   logic [7:0]  pin_v;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int m_idx(logic [31:0] a);
      logic [31:0] b;
      logic [31:0] d;
      b = BASE;
      d = ({a[31:2], 2'b00} - {b[31:2], 2'b00}) >> 2;
      return (d < 5) ? int'(d) : -1;
   endfunction

   function automatic logic [31:0] m_read(logic [31:0] a);
      int n;
      n = m_fifo.size();
      case (m_idx(a))
         0: return m_pout;
         1: return {24'b0, m_pins[1]};
         2: return {24'b0, m_ov, m_cf, 4'(n), n == D, n == 0};
         4: return (n == 0) ? 32'h0 : {24'b0, m_fifo[0]};
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_edge(bit r, logic [31:0] a, logic [31:0] wd,
                         bit mw, bit mr, logic [7:0] pin);
      int  idx;
      bit  push;
      bit  ovf;
      if (r) begin
         m_pout = '0;
         m_pins = {8'h00, 8'h00, 8'h00};
         m_fifo.delete();
         m_cf = 0;
         m_ov = 0;
         return;
      end
      idx  = m_idx(a);
      push = (m_pins[1] != m_pins[0]);
      ovf  = 0;
      if (mr && idx == 4 && m_fifo.size() > 0) void'(m_fifo.pop_front());
      if (push) begin
         if (m_fifo.size() < D) m_fifo.push_back(m_pins[1]);
         else ovf = 1;
      end
      if (mw && idx == 3) begin
         if (wd[0]) m_cf = 0;
         if (wd[1]) m_ov = 0;
      end
      if (push) m_cf = 1;
      if (ovf) m_ov = 1;
      if (mw && idx == 0) m_pout = wd;
      m_pins.push_back(pin);
      void'(m_pins.pop_front());
   endtask

   task automatic cyc(bit r, logic [31:0] a, logic [31:0] wd,
                      bit mw, bit mr, string nm);
      exp_t e;
      reset     = r;
      Address   = a;
      WriteData = wd;
      MemWrite  = mw;
      MemRead   = mr;
      PortIn    = pin_v;
      if (mr) begin
         e.name = nm;
         e.data = m_read(a);
         e.hit  = (m_idx(a) >= 0);
         e.pout = m_pout;
         sb.push_back(e);
      end
      @(posedge clk);
      m_edge(r, a, wd, mw, mr, pin_v);
      #1;
   endtask

   task automatic rd(logic [31:0] off, string nm);
      cyc(0, BASE + off, 32'h0, 0, 1, nm);
   endtask

   task automatic wr(logic [31:0] off, logic [31:0] d);
      cyc(0, BASE + off, d, 1, 0, "wr");
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(0, 32'h0, 32'h0, 0, 0, "idle");
   endtask

   task automatic set_pins(logic [7:0] first, int n);
      for (int i = 0; i < n; i++) begin
         pin_v = first + 8'(i);
         idle(3);
      end
   endtask

   // Monitor: every load cycle presents data; compare against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (MemRead) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'h1, 32'h0);
         end else begin
            e = sb.pop_front();
            chk({e.name, ".data"}, ReadData, e.data);
            chk({e.name, ".hit"}, {31'b0, Hit}, {31'b0, e.hit});
            chk({e.name, ".pout"}, PortOut, e.pout);
         end
      end
   end

   initial begin
      m_pins = {8'h00, 8'h00, 8'h00};
      m_pout = '0;
      m_cf   = 0;
      m_ov   = 0;
      pin_v  = 8'h00;

      cyc(1, 32'h0, 32'h0, 0, 0, "rst");
      cyc(1, 32'h0, 32'h0, 0, 0, "rst");
      rd(O_STAT, "rst_status");
      rd(O_OUT, "rst_pout");
      rd(O_FIFO, "rst_fifo");
      rd(O_STAT, "post_rst_status");

      wr(O_OUT, 32'hDEAD_BEEF);
      rd(O_OUT, "pout_rd");
      rd(32'h14, "miss_14");
      wr(O_IN, 32'hFFFF_FFFF);
      rd(O_IN, "ro_store");

      pin_v = 8'h5A;
      rd(O_IN, "sync_k");
      rd(O_IN, "sync_k1");
      rd(O_STAT, "stat_k2");
      rd(O_IN, "sync_k2");
      rd(O_STAT, "stat_push");
      rd(O_FIFO, "fifo_5a");
      rd(O_FIFO, "fifo_empty");
      wr(O_CLR, 32'h3);
      rd(O_STAT, "clr_status");

      set_pins(8'h01, 5);
      rd(O_STAT, "ovf_status");
      for (int i = 0; i < 5; i++) rd(O_FIFO, "ovf_pop");
      rd(O_STAT, "drained");

      wr(O_CLR, 32'h3);
      set_pins(8'h11, 4);
      rd(O_STAT, "full_status");
      pin_v = 8'h15;
      idle(2);
      rd(O_FIFO, "pop_push_full");
      rd(O_STAT, "pop_push_stat");
      for (int i = 0; i < 4; i++) rd(O_FIFO, "pp_pop");

      set_pins(8'h21, 5);
      rd(O_FIFO, "pre_clr_pop");
      pin_v = 8'h26;
      idle(2);
      wr(O_CLR, 32'h3);
      rd(O_STAT, "clr_vs_set");
      wr(O_CLR, 32'h1);
      rd(O_STAT, "clr_cf");

      rd(O_FIFO, "to_three");
      wr(O_OUT, 32'h1234);
      rd(O_STAT, "mid_status");
      pin_v = 8'h00;
      cyc(1, BASE + O_OUT, 32'hFFFF_0000, 1, 0, "rst_mid");
      rd(O_STAT, "rst_mid_status");
      rd(O_OUT, "rst_mid_pout");
      rd(O_FIFO, "rst_mid_fifo");
      rd(O_STAT, "no_push_after_rst");

      for (int i = 0; i < 600; i++) begin
         int          r;
         logic [31:0] a;
         r = int'($urandom_range(0, 99));
         if ($urandom_range(0, 3) == 0) pin_v = 8'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) a = $urandom;
         else a = BASE + 32'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
         cyc(r < 2, a, $urandom, $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1, "rand");
      end

      MemRead  = 1'b0;
      MemWrite = 1'b0;
      @(negedge clk);
      chk("sb_drain", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
